dcache_data_stage: RTL and testbench

- Memory pipeline stage directly upstream of the writeback stage; consumes the tag-stage outputs (dt_*) and produces the dd_* instruction/mask/thread/address bundle plus the raw cache line that writeback aligns.
- Holds a simulation data array (all accesses hit), commits stores with byte enables, and squashes instructions on writeback rollback.
- Clears the array after reset with a sequencer.

---
 rtl/dcache_data_stage_pkg.sv | 45 ++++
 rtl/dcache_data_stage_sram.sv | 36 +++
 rtl/dcache_data_stage.sv | 167 ++++++++++++++++
 tb/tb_dcache_data_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_data_stage_pkg.sv
// Shared cache-line geometry, memory operation encodings and pipeline types
// for the data-cache data stage.
package dcache_data_stage_pkg;

  localparam int CACHE_LINE_BYTES        = 64;
  localparam int CACHE_LINE_BITS         = CACHE_LINE_BYTES * 8;
  localparam int CACHE_LINE_WORDS        = CACHE_LINE_BYTES / 4;
  localparam int CACHE_LINE_OFFSET_WIDTH = $clog2(CACHE_LINE_BYTES);
  localparam int VECTOR_LANES            = 16;
  localparam int NUM_THREADS             = 4;

  typedef logic [31:0]                     scalar_t;
  typedef logic [VECTOR_LANES-1:0][31:0]   vector_t;
  typedef logic [$clog2(NUM_THREADS)-1:0]  thread_idx_t;

  typedef enum logic [3:0] {
    MEM_B           = 4'd0,
    MEM_BX          = 4'd1,
    MEM_S           = 4'd2,
    MEM_SX          = 4'd3,
    MEM_L           = 4'd4,
    MEM_SYNC        = 4'd5,
    MEM_CONTROL_REG = 4'd6,
    MEM_BLOCK       = 4'd7,
    MEM_BLOCK_M     = 4'd8,
    MEM_BLOCK_IM    = 4'd9
  } fmtc_op_t;

  typedef struct packed {
    logic       is_memory_access;
    logic       is_load;
    fmtc_op_t   memory_access_type;
    logic [5:0] dest_reg;
  } decoded_instruction_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dcache_init_state_t;

  function automatic scalar_t bswap32(input scalar_t v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/dcache_data_stage_sram.sv
// Simple dual-port line array: one synchronous read, one byte-enabled write.
module sram_1r1w_byte_en #(
  parameter int DATA_WIDTH = 512,
  parameter int SIZE       = 64,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i
);

  logic [DATA_WIDTH-1:0] mem_q [SIZE];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wr_be_i[b]) mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  // Read returns the pre-write contents on a same-edge collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_data_q <= '0;
    else         rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dcache_data_stage.sv
// Data-cache data stage: line array access, store formatting, rollback squash.
// Optional alignment checking is enabled by defining DCACHE_ALIGN_CHECK_EN.
module dcache_data_stage
  import dcache_data_stage_pkg::*;
#(
  parameter int NUM_LINES     = 64,
  parameter int LINE_IDX_BITS = $clog2(NUM_LINES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dt_instruction_valid,
  input  decoded_instruction_t        dt_instruction,
  input  logic [VECTOR_LANES-1:0]     dt_mask_value,
  input  thread_idx_t                 dt_thread_idx,
  input  scalar_t                     dt_request_addr,
  input  vector_t                     dt_store_value,
  input  logic                        wb_rollback_en,
  input  thread_idx_t                 wb_rollback_thread_idx,
  output logic                        dd_busy,
  output logic                        dd_instruction_valid,
  output decoded_instruction_t        dd_instruction,
  output logic [VECTOR_LANES-1:0]     dd_mask_value,
  output thread_idx_t                 dd_thread_idx,
  output scalar_t                     dd_request_addr,
  output logic [CACHE_LINE_BITS-1:0]  dd_load_data,
  output logic                        dd_alignment_fault,
  output logic                        dbg_state_o
);

  localparam int WORD_IDX_BITS = CACHE_LINE_OFFSET_WIDTH - 2;

  dcache_init_state_t         state_q;
  logic [LINE_IDX_BITS-1:0]   init_ctr_q;
  logic                       busy_q;

  logic                       kill, issue, is_block, writes_array, store_en, align_fault;
  logic [LINE_IDX_BITS-1:0]   line_idx;
  logic [WORD_IDX_BITS-1:0]   word_idx;
  scalar_t                    lane0, st_word;
  logic [3:0]                 st_word_be;
  logic [CACHE_LINE_BITS-1:0] st_data, wr_data;
  logic [CACHE_LINE_BYTES-1:0] st_be, wr_be;
  logic [LINE_IDX_BITS-1:0]   wr_addr;
  logic                       wr_en;

  // Handshake: upstream may only present dt_instruction_valid while dd_busy is
  // low; once in RUN every valid is accepted on the next edge (no stall).
  assign kill     = wb_rollback_en && dt_instruction_valid
                    && (wb_rollback_thread_idx == dt_thread_idx);
  assign issue    = dt_instruction_valid && !kill && (state_q == RUN);
  assign line_idx = dt_request_addr[CACHE_LINE_OFFSET_WIDTH +: LINE_IDX_BITS];
  assign word_idx = dt_request_addr[CACHE_LINE_OFFSET_WIDTH-1:2];
  assign lane0    = dt_store_value[0];
  assign is_block = dt_instruction.memory_access_type inside {MEM_BLOCK, MEM_BLOCK_M, MEM_BLOCK_IM};

  // Line bytes are big-endian: byte 0 of the line lives in the top bits.
  always_comb begin
    st_word      = '0;
    st_word_be   = '0;
    writes_array = 1'b0;
    case (dt_instruction.memory_access_type)
      MEM_B: begin
        st_word      = {4{lane0[7:0]}};
        st_word_be   = 4'b1000 >> dt_request_addr[1:0];
        writes_array = 1'b1;
      end
      MEM_S: begin
        st_word      = {2{lane0[15:0]}};
        st_word_be   = dt_request_addr[1] ? 4'b0011 : 4'b1100;
        writes_array = 1'b1;
      end
      MEM_L, MEM_SYNC: begin
        st_word      = lane0;
        st_word_be   = 4'b1111;
        writes_array = 1'b1;
      end
      MEM_BLOCK, MEM_BLOCK_M, MEM_BLOCK_IM: writes_array = 1'b1;
      default: ;
    endcase
    st_data = {CACHE_LINE_WORDS{st_word}};
    st_be   = {{(CACHE_LINE_BYTES-4){1'b0}}, st_word_be}
              << ((CACHE_LINE_WORDS - 1 - int'(word_idx)) * 4);
    if (is_block) begin
      for (int w = 0; w < VECTOR_LANES; w++) begin
        st_data[(CACHE_LINE_WORDS-1-w)*32 +: 32] = bswap32(dt_store_value[w]);
        st_be[(CACHE_LINE_WORDS-1-w)*4 +: 4]     = {4{dt_mask_value[w]}};
      end
    end
  end

`ifdef DCACHE_ALIGN_CHECK_EN
  always_comb begin
    align_fault = 1'b0;
    case (dt_instruction.memory_access_type)
      MEM_S, MEM_SX:   align_fault = dt_request_addr[0];
      MEM_L, MEM_SYNC: align_fault = |dt_request_addr[1:0];
      MEM_BLOCK, MEM_BLOCK_M, MEM_BLOCK_IM:
                       align_fault = |dt_request_addr[CACHE_LINE_OFFSET_WIDTH-1:0];
      default:         align_fault = 1'b0;
    endcase
  end
`else
  assign align_fault = 1'b0;
`endif

  assign store_en = issue && dt_instruction.is_memory_access && !dt_instruction.is_load
                    && writes_array && !align_fault;

  // The init sequencer owns the write port until every line is cleared.
  assign wr_en   = (state_q == INIT) || store_en;
  assign wr_addr = (state_q == INIT) ? init_ctr_q : line_idx;
  assign wr_be   = (state_q == INIT) ? '1 : st_be;
  assign wr_data = (state_q == INIT) ? '0 : st_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      init_ctr_q <= '0;
      busy_q     <= 1'b1;
    end else if (state_q == INIT) begin
      init_ctr_q <= init_ctr_q + 1'b1;
      if (init_ctr_q == LINE_IDX_BITS'(NUM_LINES - 1)) begin
        state_q <= RUN;
        busy_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dd_instruction_valid <= 1'b0;
      dd_instruction       <= '0;
      dd_mask_value        <= '0;
      dd_thread_idx        <= '0;
      dd_request_addr      <= '0;
      dd_alignment_fault   <= 1'b0;
    end else begin
      dd_instruction_valid <= issue;
      dd_instruction       <= dt_instruction;
      dd_mask_value        <= dt_mask_value;
      dd_thread_idx        <= dt_thread_idx;
      dd_request_addr      <= dt_request_addr;
      dd_alignment_fault   <= issue && align_fault;
    end
  end

  sram_1r1w_byte_en #(
    .DATA_WIDTH (CACHE_LINE_BITS),
    .SIZE       (NUM_LINES)
  ) u_data_array (
    .clk_i     (clk),
    .rst_ni    (reset),
    .rd_addr_i (line_idx),
    .rd_data_o (dd_load_data),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_be_i   (wr_be),
    .wr_data_i (wr_data)
  );

  assign dd_busy     = busy_q;
  assign dbg_state_o = state_q;

  issue_while_busy: assert property (@(posedge clk) disable iff (!reset)
    !(busy_q && dt_instruction_valid));

endmodule

// File: tb/tb_dcache_data_stage.sv
// Directed self-checking bench for dcache_data_stage.
`timescale 1ns/1ps
module tb_dcache_data_stage;
  import dcache_data_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       dt_instruction_valid;
  decoded_instruction_t       dt_instruction;
  logic [VECTOR_LANES-1:0]    dt_mask_value;
  thread_idx_t                dt_thread_idx;
  scalar_t                    dt_request_addr;
  vector_t                    dt_store_value;
  logic                       wb_rollback_en;
  thread_idx_t                wb_rollback_thread_idx;
  logic                       dd_busy;
  logic                       dd_instruction_valid;
  decoded_instruction_t       dd_instruction;
  logic [VECTOR_LANES-1:0]    dd_mask_value;
  thread_idx_t                dd_thread_idx;
  scalar_t                    dd_request_addr;
  logic [CACHE_LINE_BITS-1:0] dd_load_data;
  logic                       dd_alignment_fault;
  logic                       dbg_state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  dcache_data_stage dut (
    .clk                    (clk),
    .reset                  (reset),
    .dt_instruction_valid   (dt_instruction_valid),
    .dt_instruction         (dt_instruction),
    .dt_mask_value          (dt_mask_value),
    .dt_thread_idx          (dt_thread_idx),
    .dt_request_addr        (dt_request_addr),
    .dt_store_value         (dt_store_value),
    .wb_rollback_en         (wb_rollback_en),
    .wb_rollback_thread_idx (wb_rollback_thread_idx),
    .dd_busy                (dd_busy),
    .dd_instruction_valid   (dd_instruction_valid),
    .dd_instruction         (dd_instruction),
    .dd_mask_value          (dd_mask_value),
    .dd_thread_idx          (dd_thread_idx),
    .dd_request_addr        (dd_request_addr),
    .dd_load_data           (dd_load_data),
    .dd_alignment_fault     (dd_alignment_fault),
    .dbg_state_o            (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CACHE_LINE_BITS-1:0] got,
                       input logic [CACHE_LINE_BITS-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic scalar_t word_of(input logic [CACHE_LINE_BITS-1:0] line, input int w);
    return line[(CACHE_LINE_WORDS-1-w)*32 +: 32];
  endfunction

  function automatic scalar_t swap_bytes(input scalar_t v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // driver: present one instruction, let it cross one edge, sample #1 after
  task automatic issue(input fmtc_op_t op, input logic ld, input scalar_t addr,
                       input vector_t sv, input logic [15:0] mask, input thread_idx_t tid,
                       input logic rb_en, input thread_idx_t rb_tid);
    dt_instruction_valid   = 1'b1;
    dt_instruction         = '{is_memory_access: 1'b1, is_load: ld,
                               memory_access_type: op, dest_reg: 6'd3};
    dt_request_addr        = addr;
    dt_store_value         = sv;
    dt_mask_value          = mask;
    dt_thread_idx          = tid;
    wb_rollback_en         = rb_en;
    wb_rollback_thread_idx = rb_tid;
    @(posedge clk); #1;
    dt_instruction_valid   = 1'b0;
    wb_rollback_en         = 1'b0;
  endtask

  task automatic store_scalar(input fmtc_op_t op, input scalar_t addr, input scalar_t v);
    vector_t sv;
    sv = '0;
    sv[0] = v;
    issue(op, 1'b0, addr, sv, 16'hFFFF, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic load_line(input scalar_t addr);
    issue(MEM_BLOCK, 1'b1, addr, '0, 16'hFFFF, 2'd0, 1'b0, 2'd0);
  endtask

  initial begin
    vector_t sv;
    int busy_cycles;

    reset                  = 1'b0;
    dt_instruction_valid   = 1'b0;
    dt_instruction         = '0;
    dt_mask_value          = '0;
    dt_thread_idx          = '0;
    dt_request_addr        = '0;
    dt_store_value         = '0;
    wb_rollback_en         = 1'b0;
    wb_rollback_thread_idx = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  dd_busy, 1);
    check("rst_valid", dd_instruction_valid, 0);
    check("rst_load",  dd_load_data, 0);
    check("rst_addr",  dd_request_addr, 0);
    check("rst_fault", dd_alignment_fault, 0);
    check("rst_state", dbg_state_o, INIT);

    reset = 1'b1;
    busy_cycles = 0;
    while (dd_busy && busy_cycles < 200) begin
      @(posedge clk); #1;
      busy_cycles++;
    end
    check("init_cycles", busy_cycles, 64);
    check("run_state",   dbg_state_o, RUN);

    load_line(32'h40);
    check("ld40_valid", dd_instruction_valid, 1);
    check("ld40_addr",  dd_request_addr, 32'h40);
    check("ld40_zero",  dd_load_data, 0);

    store_scalar(MEM_L, 32'h100, 32'h11223344);
    check("stl_valid", dd_instruction_valid, 1);
    load_line(32'h100);
    check("ldl_valid", dd_instruction_valid, 1);
    check("ldl_w0",    word_of(dd_load_data, 0), 32'h11223344);
    check("ldl_w1",    word_of(dd_load_data, 1), 32'h0);

    store_scalar(MEM_B, 32'h202, 32'hFFFFFFAB);
    store_scalar(MEM_S, 32'h206, 32'h1234BEEF);
    load_line(32'h200);
    check("stb_w0", word_of(dd_load_data, 0), 32'h0000AB00);
    check("sts_w1", word_of(dd_load_data, 1), 32'h0000BEEF);

    for (int w = 0; w < VECTOR_LANES; w++) sv[w] = 32'hA0000000 | w;
    issue(MEM_BLOCK, 1'b0, 32'h300, sv, 16'hFFFF, 2'd0, 1'b0, 2'd0);
    for (int w = 0; w < VECTOR_LANES; w++) sv[w] = w;
    issue(MEM_BLOCK, 1'b0, 32'h300, sv, 16'h00FF, 2'd1, 1'b0, 2'd0);
    check("blk_mask",   dd_mask_value, 16'h00FF);
    check("blk_thread", dd_thread_idx, 2'd1);
    load_line(32'h300);
    check("blk_w0",  word_of(dd_load_data, 0),  swap_bytes(32'h0));
    check("blk_w7",  word_of(dd_load_data, 7),  swap_bytes(32'h7));
    check("blk_w8",  word_of(dd_load_data, 8),  swap_bytes(32'hA0000008));
    check("blk_w15", word_of(dd_load_data, 15), swap_bytes(32'hA000000F));

    sv = '0;
    sv[0] = 32'hDEADBEEF;
    issue(MEM_L, 1'b0, 32'h100, sv, 16'hFFFF, 2'd2, 1'b1, 2'd2);
    check("kill_valid", dd_instruction_valid, 0);
    load_line(32'h100);
    check("kill_mem", word_of(dd_load_data, 0), 32'h11223344);
    issue(MEM_L, 1'b0, 32'h100, sv, 16'hFFFF, 2'd2, 1'b1, 2'd1);
    check("other_rb_valid",  dd_instruction_valid, 1);
    check("other_rb_thread", dd_thread_idx, 2'd2);
    load_line(32'h100);
    check("other_rb_mem", word_of(dd_load_data, 0), 32'hDEADBEEF);

    store_scalar(MEM_L, 32'h102, 32'hCAFEF00D);
`ifdef DCACHE_ALIGN_CHECK_EN
    check("align_fault", dd_alignment_fault, 1);
    load_line(32'h100);
    check("align_mem", word_of(dd_load_data, 0), 32'hDEADBEEF);
`else
    check("align_fault", dd_alignment_fault, 0);
    load_line(32'h100);
    check("align_mem", word_of(dd_load_data, 0), 32'hCAFEF00D);
`endif

    repeat (2) @(posedge clk); #1;
    check("idle_valid", dd_instruction_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
